lfsr_gen: RTL and testbench
===========================

# lfsr_gen

Parametrised Fibonacci LFSR with a built-in step prescaler, seed load, all-zero lock-up recovery and period measurement. It supersedes the pairing of a derived slow clock with a fixed 14-bit LFSR. The whole block runs on the board clock, and stepping is gated by an internal clock-enable tick instead of a divided clock. It sits between the board clock input and any pseudo-random consumer: display test patterns, noise sources, or BIST stimulus.

## Interface
Parameters:
- WIDTH, 14: LFSR state width, 2..32.
- TAPS, 14'h3500: feedback mask. Bit i set means state[i] is XORed into the feedback. The default realises x^14+x^5+x^3+x+1.
- SEED, 1: state after reset and the wrap reference. Must be non-zero.
- DIV, 50_000_000: board clock cycles per LFSR step, 1..2^32-1. DIV=1 steps on every enabled cycle.

Ports:
- clk, input, 1: board clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- en, input, 1: run enable; the prescaler advances only while en=1.
- load, input, 1: synchronous seed load, one-cycle strobe.
- load_val, input, WIDTH: value loaded on load.
- lfsr_out, output, WIDTH: current LFSR state.
- tick, output, 1: one-cycle pulse in the cycle lfsr_out takes a stepped value.
- max_tick, output, 1: one-cycle pulse when a step returns the state to SEED.
- lockup, output, 1: one-cycle pulse when a zero state or zero load is replaced by SEED.
- step_cnt, output, WIDTH: steps since the last reset, load or wrap.
- period_out, output, WIDTH: length of the last completed period. Holds 0 until the first wrap.

## Operation
- Feedback:
  - fb = XOR-reduce(state & TAPS).
  - next = {state[WIDTH-2:0], fb}, a left shift with fb entering bit 0.
- Prescaler:
  - pcnt counts 0..DIV-1 while en=1 and holds while en=0.
  - step = en && pcnt==DIV-1.
  - On step, pcnt returns to 0.
- On a step:
  - If state==0, state<=SEED and lockup pulses. step_cnt is unaffected.
  - Otherwise state<=next. Then:
    - If next==SEED: max_tick pulses, period_out<=step_cnt+1, step_cnt<=0.
    - Else step_cnt<=step_cnt+1, wrapping modulo 2^WIDTH.
  - tick pulses on every step.
- Load, which has priority over a same-cycle step:
  - state<=(load_val==0 ? SEED : load_val). lockup pulses when load_val==0.
  - pcnt<=0 and step_cnt<=0. period_out is kept.
  - tick and max_tick stay 0 in that cycle.
- The state register carries no FSM beyond the prescaler. The two modes are RUN (en=1) and HOLD (en=0). HOLD freezes pcnt, state and the counters.

## Timing
- Reset (reset=0, asynchronous):
  - lfsr_out=SEED.
  - pcnt=0, step_cnt=0, period_out=0.
  - tick=0, max_tick=0, lockup=0.
- Release is synchronous in effect: the first prescaler increment is on the first rising edge with reset=1 and en=1.
- All outputs are registered, with no combinational path from inputs to outputs.
- tick, max_tick and lockup are asserted in the same cycle lfsr_out shows the new value, and last exactly one cycle.
- Step latency: after en rises with pcnt=0, the first step is visible DIV cycles later.
- Back-to-back steps are DIV cycles apart.
- en falling mid-count preserves pcnt. Re-asserting en resumes the count without restarting it.
- Load latency: one cycle. lfsr_out=load_val on the edge after load=1.
- load and step in the same cycle: load wins and no tick occurs.
- Reset asserted mid-count: all state clears immediately, independent of clk.

## Test plan
- Reset and hold: WIDTH=4, TAPS=4'h9, SEED=1, DIV=4, en=0 for 20 cycles -> lfsr_out=0001, no tick, step_cnt=0.
- Sequence and period: same parameters with en=1 -> a tick every 4 cycles, and lfsr_out follows 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, 0100, 1000, 0001. max_tick pulses with the 15th step, period_out=15 and step_cnt=0.
- Pause/resume: drop en after 2 enabled cycles for 10 cycles, then restore -> the first tick comes 2 enabled cycles later with lfsr_out=0011.
- Load, including zero: load=1, load_val=1010 -> lfsr_out=1010, step_cnt=0, the next tick gives 0101. Then load with load_val=0 -> lfsr_out=0001 and lockup pulses once.
- Load vs step collision: assert load in the cycle pcnt==3 -> lfsr_out=load_val, no tick, and the next tick occurs 4 cycles later.
- Async reset mid-run: pull reset low between clock edges at step_cnt=7 -> lfsr_out=0001 and all counters 0 before the next edge. period_out=0.

Source files
------------

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR that steps on an internal prescaler tick from the board clock.
// Supports seed load, recovery from the all-zero state and period measurement.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 14,
  parameter logic [WIDTH-1:0] TAPS  = 14'h3500,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned      DIV   = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             tick,
  output logic             max_tick,
  output logic             lockup,
  output logic [WIDTH-1:0] step_cnt,
  output logic [WIDTH-1:0] period_out
);

  localparam logic [31:0] PCNT_LAST = 32'(DIV - 1);

  logic [31:0]      pcnt_q,     pcnt_d;
  logic [WIDTH-1:0] lfsrState_q, lfsrState_d;
  logic [WIDTH-1:0] stepCnt_q,  stepCnt_d;
  logic [WIDTH-1:0] period_q,   period_d;
  logic             tick_q,     tick_d;
  logic             maxTick_q,  maxTick_d;
  logic             lockup_q,   lockup_d;

  logic             stepNow;
  logic             feedback;
  logic [WIDTH-1:0] shifted;

  assign stepNow  = en && (pcnt_q == PCNT_LAST);
  assign feedback = ^(lfsrState_q & TAPS);
  assign shifted  = {lfsrState_q[WIDTH-2:0], feedback};

  // Load takes priority over a step that falls in the same cycle.
  always_comb begin
    pcnt_d      = pcnt_q;
    lfsrState_d = lfsrState_q;
    stepCnt_d   = stepCnt_q;
    period_d    = period_q;
    tick_d      = 1'b0;
    maxTick_d   = 1'b0;
    lockup_d    = 1'b0;

    if (load) begin
      pcnt_d    = '0;
      stepCnt_d = '0;
      if (load_val == '0) begin
        lfsrState_d = SEED;
        lockup_d    = 1'b1;
      end else begin
        lfsrState_d = load_val;
      end
    end else if (en) begin
      if (stepNow) begin
        pcnt_d = '0;
        tick_d = 1'b1;
        if (lfsrState_q == '0) begin
          lfsrState_d = SEED;
          lockup_d    = 1'b1;
        end else begin
          lfsrState_d = shifted;
          if (shifted == SEED) begin
            maxTick_d = 1'b1;
            period_d  = stepCnt_q + WIDTH'(1);
            stepCnt_d = '0;
          end else begin
            stepCnt_d = stepCnt_q + WIDTH'(1);
          end
        end
      end else begin
        pcnt_d = pcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q      <= '0;
      lfsrState_q <= SEED;
      stepCnt_q   <= '0;
      period_q    <= '0;
      tick_q      <= 1'b0;
      maxTick_q   <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      lfsrState_q <= lfsrState_d;
      stepCnt_q   <= stepCnt_d;
      period_q    <= period_d;
      tick_q      <= tick_d;
      maxTick_q   <= maxTick_d;
      lockup_q    <= lockup_d;
    end
  end

  assign lfsr_out   = lfsrState_q;
  assign tick       = tick_q;
  assign max_tick   = maxTick_q;
  assign lockup     = lockup_q;
  assign step_cnt   = stepCnt_q;
  assign period_out = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: directed scenarios on a 4-bit maximal LFSR plus random
// en/load traffic on two instances checked against a behavioural model.
module tb_lfsr_gen;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] out0, out1, step0, step1, per0, per1;
  logic         tick0, tick1, max0, max1, lock0, lock1;

  int checks = 0;
  int failures = 0;

  // Instance 0 is maximal length; instance 1 has a short orbit and a reachable zero.
  int mDiv[2]  = '{4, 1};
  int mTaps[2] = '{9, 3};
  int mSeed[2] = '{1, 5};
  int mState[2], mPcnt[2], mStep[2], mPer[2];
  bit mTick[2], mMax[2], mLock[2];

  logic [3:0] seq [15] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                           4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};

  lfsr_gen #(.WIDTH(W), .TAPS(4'h9), .SEED(4'h1), .DIV(4)) u0 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .lfsr_out(out0), .tick(tick0), .max_tick(max0), .lockup(lock0),
    .step_cnt(step0), .period_out(per0));

  lfsr_gen #(.WIDTH(W), .TAPS(4'h3), .SEED(4'h5), .DIV(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .lfsr_out(out1), .tick(tick1), .max_tick(max1), .lockup(lock1),
    .step_cnt(step1), .period_out(per1));

  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mState[i] = mSeed[i];
      mPcnt[i] = 0; mStep[i] = 0; mPer[i] = 0;
      mTick[i] = 0; mMax[i] = 0; mLock[i] = 0;
    end
  endtask

  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      int par, nxt;
      mTick[i] = 0; mMax[i] = 0; mLock[i] = 0;
      if (load) begin
        mState[i] = (load_val == 0) ? mSeed[i] : int'(load_val);
        mLock[i] = (load_val == 0);
        mPcnt[i] = 0; mStep[i] = 0;
      end else if (en) begin
        mPcnt[i] = mPcnt[i] + 1;
        if (mPcnt[i] == mDiv[i]) begin
          mPcnt[i] = 0; mTick[i] = 1;
          if (mState[i] == 0) begin
            mState[i] = mSeed[i]; mLock[i] = 1;
          end else begin
            par = $countones(mState[i] & mTaps[i]) % 2;
            nxt = (mState[i] * 2 + par) % 16;
            mState[i] = nxt;
            if (nxt == mSeed[i]) begin
              mMax[i] = 1; mPer[i] = (mStep[i] + 1) % 16; mStep[i] = 0;
            end else begin
              mStep[i] = (mStep[i] + 1) % 16;
            end
          end
        end
      end
    end
  endtask

  task automatic clk1();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b0; en = 1'b0; load = 1'b0; load_val = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    applyReset();
    checks++;
    if (out0 !== 4'h1 || step0 !== 4'h0 || per0 !== 4'h0 || {tick0, max0, lock0} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_u0 got out=%h step=%h per=%h flags=%b want 1 0 0 000",
               out0, step0, per0, {tick0, max0, lock0});
    end
    checks++;
    if (out1 !== 4'h5) begin
      failures++;
      $display("[TB] FAIL reset_u1 got out=%h want 5", out1);
    end
    for (int c = 0; c < 20; c++) begin
      clk1();
      checks++;
      if (tick0 !== 1'b0 || out0 !== 4'h1 || step0 !== 4'h0) begin
        failures++;
        $display("[TB] FAIL hold cyc=%0d got tick=%b out=%h step=%h want 0 1 0", c, tick0, out0, step0);
      end
    end
  endtask

  task automatic test_sequence();
    applyReset();
    en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      for (int c = 0; c < 3; c++) begin
        clk1();
        checks++;
        if (tick0 !== 1'b0) begin
          failures++;
          $display("[TB] FAIL seq_gap step=%0d cyc=%0d got tick=%b want 0", k, c, tick0);
        end
      end
      clk1();
      checks++;
      if (tick0 !== 1'b1 || out0 !== seq[k] || max0 !== (k == 14)) begin
        failures++;
        $display("[TB] FAIL seq_step step=%0d got tick=%b out=%h max=%b want 1 %h %b",
                 k, tick0, out0, max0, seq[k], (k == 14));
      end
    end
    checks++;
    if (per0 !== 4'd15 || step0 !== 4'd0) begin
      failures++;
      $display("[TB] FAIL period got per=%0d step=%0d want 15 0", per0, step0);
    end
    clk1();
    checks++;
    if (max0 !== 1'b0 || tick0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pulse_width got max=%b tick=%b want 0 0", max0, tick0);
    end
  endtask

  task automatic test_pause_resume();
    applyReset();
    en = 1'b1;
    repeat (2) clk1();
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      clk1();
      checks++;
      if (tick0 !== 1'b0 || out0 !== 4'h1) begin
        failures++;
        $display("[TB] FAIL paused cyc=%0d got tick=%b out=%h want 0 1", c, tick0, out0);
      end
    end
    en = 1'b1;
    clk1();
    checks++;
    if (tick0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL resume_early got tick=%b want 0", tick0);
    end
    clk1();
    checks++;
    if (tick0 !== 1'b1 || out0 !== 4'h3) begin
      failures++;
      $display("[TB] FAIL resume_step got tick=%b out=%h want 1 3", tick0, out0);
    end
  endtask

  task automatic test_load();
    applyReset();
    en = 1'b1;
    repeat (9) clk1();
    load = 1'b1; load_val = 4'hA;
    clk1();
    load = 1'b0;
    checks++;
    if (out0 !== 4'hA || step0 !== 4'h0 || tick0 !== 1'b0 || lock0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_val got out=%h step=%h tick=%b lock=%b want a 0 0 0", out0, step0, tick0, lock0);
    end
    repeat (3) clk1();
    clk1();
    checks++;
    if (tick0 !== 1'b1 || out0 !== 4'h5) begin
      failures++;
      $display("[TB] FAIL load_next got tick=%b out=%h want 1 5", tick0, out0);
    end
    load = 1'b1; load_val = 4'h0;
    clk1();
    load = 1'b0;
    checks++;
    if (out0 !== 4'h1 || lock0 !== 1'b1 || out1 !== 4'h5 || lock1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_zero got out0=%h lock0=%b out1=%h lock1=%b want 1 1 5 1", out0, lock0, out1, lock1);
    end
    clk1();
    checks++;
    if (lock0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lockup_width got lock=%b want 0", lock0);
    end
  endtask

  task automatic test_collision();
    logic [W-1:0] v;
    applyReset();
    en = 1'b1;
    repeat (3) clk1();
    v = 4'($urandom_range(1, 15));
    load = 1'b1; load_val = v;
    clk1();
    load = 1'b0;
    checks++;
    if (out0 !== v || tick0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL collision got out=%h tick=%b want %h 0", out0, tick0, v);
    end
    for (int c = 0; c < 3; c++) begin
      clk1();
      checks++;
      if (tick0 !== 1'b0) begin
        failures++;
        $display("[TB] FAIL collision_gap cyc=%0d got tick=%b want 0", c, tick0);
      end
    end
    clk1();
    checks++;
    if (tick0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL collision_step got tick=%b want 1", tick0);
    end
  endtask

  task automatic test_async_reset();
    applyReset();
    en = 1'b1;
    repeat (28) clk1();
    checks++;
    if (step0 !== 4'd7) begin
      failures++;
      $display("[TB] FAIL pre_reset_cnt got step=%0d want 7", step0);
    end
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checks++;
    if (out0 !== 4'h1 || step0 !== 4'h0 || per0 !== 4'h0 || {tick0, max0, lock0} !== 3'b000 || out1 !== 4'h5) begin
      failures++;
      $display("[TB] FAIL async_reset got out=%h step=%h per=%h flags=%b out1=%h want 1 0 0 000 5",
               out0, step0, per0, {tick0, max0, lock0}, out1);
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [14:0] act, exp;
    applyReset();
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 59) == 0);
      load_val = 4'($urandom_range(0, 15));
      clk1();
      act = {out0, tick0, max0, lock0, step0, per0};
      exp = {4'(mState[0]), mTick[0], mMax[0], mLock[0], 4'(mStep[0]), 4'(mPer[0])};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("[TB] FAIL random_u0 cyc=%0d got %h want %h", c, act, exp);
      end
      act = {out1, tick1, max1, lock1, step1, per1};
      exp = {4'(mState[1]), mTick[1], mMax[1], mLock[1], 4'(mStep[1]), 4'(mPer[1])};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("[TB] FAIL random_u1 cyc=%0d got %h want %h", c, act, exp);
      end
    end
    en = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_pause_resume();
    test_load();
    test_collision();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
